vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- HD, 640, active pixels per line.
- HF, 16, horizontal front porch.
- HS, 96, hsync width.
- HB, 48, horizontal back porch.
- VD, 480, active lines.
- VF, 10, vertical front porch.
- VS, 2, vsync width in lines.
- VB, 33, vertical back porch.
- HPOL, 0, hsync active level (0 = active-low).
- VPOL, 0, vsync active level (0 = active-low).
- CW, 10, position counter width.
- FW, 8, frame counter width.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- pclk  in  1  pixel clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  count enable; low freezes the timing.
- hsync  out  1  horizontal sync at level HPOL when active.
- vsync  out  1  vertical sync at level VPOL when active.
- valid  out  1  active-video (display enable).
- h_pos  out  CW  raw horizontal position, 0..HT-1.
- v_pos  out  CW  raw vertical position, 0..VT-1.
- h_cnt  out  CW  h_pos when active, else 0.
- v_cnt  out  CW  v_pos when active, else 0.
- line_start  out  1  one-cycle pulse at h_pos==0.
- frame_start  out  1  one-cycle pulse at h_pos==0 and v_pos==0.
- vblank_start  out  1  one-cycle pulse at h_pos==0 and v_pos==VD.
- frame_cnt  out  FW  count of completed frames, wrapping.
REQ-003 The parameters SHALL satisfy HT=HD+HF+HS+HB and VT=VD+VF+VS+VB; HT-1 and VT-1 SHALL fit in CW bits.

Function
REQ-004 h_pos SHALL advance by 1 on each enabled cycle and wrap from HT-1 to 0.
REQ-005 v_pos SHALL advance by 1 only on an enabled cycle where h_pos==HT-1, and SHALL wrap from VT-1 to 0 on that same cycle.
REQ-006 All outputs SHALL be registered and mutually aligned: every decoded output describes the h_pos/v_pos value presented in the same cycle, with no cycle skew between sync, valid and the positions.
REQ-007 hsync SHALL equal HPOL when HD+HF <= h_pos <= HD+HF+HS-1, and ~HPOL otherwise.
REQ-008 vsync SHALL equal VPOL when VD+VF <= v_pos <= VD+VF+VS-1, for every h_pos of those lines, and ~VPOL otherwise.
REQ-009 valid SHALL be 1 if and only if h_pos < HD and v_pos < VD.
REQ-010 h_cnt SHALL equal h_pos when h_pos < HD and 0 otherwise; v_cnt SHALL equal v_pos when v_pos < VD and 0 otherwise.
REQ-011 line_start, frame_start and vblank_start SHALL each be high for exactly one enabled cycle per occurrence of their position condition.
REQ-012 frame_cnt SHALL increment on the enabled cycle where h_pos==HT-1 and v_pos==VT-1, and SHALL wrap from 2^FW-1 to 0.
REQ-013 When en=0, all counters and all outputs SHALL hold their values, and the pulse outputs SHALL be forced to 0 on those cycles.
REQ-014 When en returns to 1, counting SHALL resume from the held position without skipping or repeating a position.

Reset
REQ-015 While reset=0 at a pclk edge, the block SHALL drive h_pos=0, v_pos=0, frame_cnt=0, hsync=~HPOL, vsync=~VPOL, valid=0, h_cnt=0, v_cnt=0 and all pulse outputs to 0.
REQ-016 reset SHALL take priority over en.
REQ-017 A reset asserted mid-frame SHALL abandon the frame and SHALL NOT increment frame_cnt.
REQ-018 On the first enabled cycle after reset is released, the block SHALL present h_pos=0, v_pos=0, valid=1, line_start=1 and frame_start=1.

Verification
REQ-019 Defaults, en=1, release reset: first cycle h_pos=0, v_pos=0, valid=1, frame_start=1; a complete frame takes 420000 cycles; frame_cnt=1 at the next frame_start.
REQ-020 Defaults, one line: hsync low for exactly h_pos 656..751 (96 cycles); valid low for h_pos 640..799; h_cnt=0 throughout h_pos 640..799.
REQ-021 Defaults, one frame: vsync low for exactly lines 490..491 (1600 cycles); vblank_start pulses once, at v_pos=480 and h_pos=0.
REQ-022 HPOL=1, VPOL=1, HD=8, HF=2, HS=3, HB=3, VD=4, VF=1, VS=1, VB=2: HT=16 and VT=8; hsync high only at h_pos 10..12; frame period 128 cycles.
REQ-023 Drive en=0 for 5 cycles at h_pos=799, v_pos=524: all outputs frozen and pulses 0; on re-enable the next cycle shows h_pos=0, v_pos=0, frame_start=1 and frame_cnt incremented by 1.
REQ-024 Preset frame_cnt to 255 with FW=8, then assert reset at v_pos=300: frame_cnt wraps to 0 at the wrap test point; the mid-frame reset yields all reset values on the next cycle and frame_cnt is not incremented.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with registered, mutually aligned sync/valid/position outputs
module vga_timing_gen #(
    parameter int HD   = 640,
    parameter int HF   = 16,
    parameter int HS   = 96,
    parameter int HB   = 48,
    parameter int VD   = 480,
    parameter int VF   = 10,
    parameter int VS   = 2,
    parameter int VB   = 33,
    parameter bit HPOL = 1'b0,
    parameter bit VPOL = 1'b0,
    parameter int CW   = 10,
    parameter int FW   = 8
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [CW-1:0] h_pos,
    output logic [CW-1:0] v_pos,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(HD);
    localparam logic [CW-1:0] V_ACT  = CW'(VD);
    localparam logic [CW-1:0] HS_BEG = CW'(HD + HF);
    localparam logic [CW-1:0] HS_END = CW'(HD + HF + HS - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(VD + VF);
    localparam logic [CW-1:0] VS_END = CW'(VD + VF + VS - 1);

    // started=0 means the first enabled cycle after reset presents (0,0) rather than advancing
    logic          started;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          frame_done;
    logic          ls_q;
    logic          fs_q;
    logic          vbs_q;

    always_comb begin
        h_nxt      = '0;
        v_nxt      = '0;
        frame_done = 1'b0;
        if (started) begin
            if (h_pos == H_LAST) begin
                h_nxt = '0;
                if (v_pos == V_LAST) begin
                    v_nxt      = '0;
                    frame_done = 1'b1;
                end else begin
                    v_nxt = v_pos + 1'b1;
                end
            end else begin
                h_nxt = h_pos + 1'b1;
                v_nxt = v_pos;
            end
        end
    end

    // Every registered output is decoded from the same next position, so nothing skews
    always_ff @(posedge pclk) begin
        if (!reset) begin
            started   <= 1'b0;
            h_pos     <= '0;
            v_pos     <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            hsync     <= ~HPOL;
            vsync     <= ~VPOL;
            valid     <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            vbs_q     <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            started   <= 1'b1;
            h_pos     <= h_nxt;
            v_pos     <= v_nxt;
            h_cnt     <= (h_nxt < H_ACT) ? h_nxt : '0;
            v_cnt     <= (v_nxt < V_ACT) ? v_nxt : '0;
            hsync     <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HPOL : ~HPOL;
            vsync     <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VPOL : ~VPOL;
            valid     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            ls_q      <= (h_nxt == '0);
            fs_q      <= (h_nxt == '0) && (v_nxt == '0);
            vbs_q     <= (h_nxt == '0) && (v_nxt == V_ACT);
            frame_cnt <= frame_cnt + FW'(frame_done);
        end
    end

    // Pulses are held while frozen but only shown on enabled cycles
    assign line_start   = ls_q & en;
    assign frame_start  = fs_q & en;
    assign vblank_start = vbs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: default and small-raster instances against a position model
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic mon;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_vl, d_ls, d_fs, d_vb;
    logic [9:0] d_h, d_v, d_hc, d_vc;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_vl, s_ls, s_fs, s_vb;
    logic [9:0] s_h, s_v, s_hc, s_vc;
    logic [7:0] s_fc;

    vga_timing_gen dut_d (
        .pclk(clk), .reset(reset), .en(en),
        .hsync(d_hs), .vsync(d_vs), .valid(d_vl),
        .h_pos(d_h), .v_pos(d_v), .h_cnt(d_hc), .v_cnt(d_vc),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
        .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .HD(8), .HF(2), .HS(3), .HB(3), .VD(4), .VF(1), .VS(1), .VB(2),
        .HPOL(1'b1), .VPOL(1'b1)
    ) dut_s (
        .pclk(clk), .reset(reset), .en(en),
        .hsync(s_hs), .vsync(s_vs), .valid(s_vl),
        .h_pos(s_h), .v_pos(s_v), .h_cnt(s_hc), .v_cnt(s_vc),
        .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
        .frame_cnt(s_fc)
    );

    logic [53:0] vec_d, vec_s;
    assign vec_d = {d_hs, d_vs, d_vl, d_h, d_v, d_hc, d_vc, d_ls, d_fs, d_vb, d_fc};
    assign vec_s = {s_hs, s_vs, s_vl, s_h, s_v, s_hc, s_vc, s_ls, s_fs, s_vb, s_fc};

    function automatic logic [53:0] pk(logic hs, logic vs, logic vl, int h, int v, int hc, int vc,
                                       logic ls, logic fs, logic vb, int fc);
        return {hs, vs, vl, 10'(h), 10'(v), 10'(hc), 10'(vc), ls, fs, vb, 8'(fc)};
    endfunction

    // Outputs follow from the count t of enabled cycles since reset release (t<0: not started)
    function automatic logic [53:0] model(int t, int fc, logic e, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, logic hp, logic vp);
        int ht, h, v;
        ht = hd + hf + hs + hb;
        if (t < 0) return pk(~hp, ~vp, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        h = t % ht;
        v = t / ht;
        return pk((h >= hd + hf && h < hd + hf + hs) ? hp : ~hp,
                  (v >= vd + vf && v < vd + vf + vs) ? vp : ~vp,
                  h < hd && v < vd, h, v, (h < hd) ? h : 0, (v < vd) ? v : 0,
                  e && h == 0, e && h == 0 && v == 0, e && h == 0 && v == vd, fc);
    endfunction

    int t_d, fc_d, t_s, fc_s;
    always @(posedge clk) begin
        if (!reset) begin
            t_d <= -1; fc_d <= 0; t_s <= -1; fc_s <= 0;
        end else if (en) begin
            if (t_d < 0) t_d <= 0;
            else if (t_d == 420000 - 1) begin t_d <= 0; fc_d <= (fc_d + 1) % 256; end
            else t_d <= t_d + 1;
            if (t_s < 0) t_s <= 0;
            else if (t_s == 128 - 1) begin t_s <= 0; fc_s <= (fc_s + 1) % 256; end
            else t_s <= t_s + 1;
        end
    end

    task automatic chk(input string nm, input logic [53:0] act, input logic [53:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon) begin
            chk("model_small", vec_s, model(t_s, fc_s, en, 8, 2, 3, 3, 4, 1, 1, 1'b1, 1'b1));
            chk("model_default", vec_d, model(t_d, fc_d, en, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drv(input logic r, input logic e);
        #1;
        reset = r;
        en    = e;
    endtask

    typedef struct {
        int t; logic hs; logic vs; logic vl; int h; int v; int hc; int vc;
        logic ls; logic fs; logic vb; int fc;
    } vec_t;

    vec_t tbl[14];
    int   cur;

    initial begin
        tbl[0]  = '{0,   0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0};
        tbl[1]  = '{7,   0, 0, 1, 7,  0, 7, 0, 0, 0, 0, 0};
        tbl[2]  = '{8,   0, 0, 0, 8,  0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{10,  1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{12,  1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{13,  0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{16,  0, 0, 1, 0,  1, 0, 1, 1, 0, 0, 0};
        tbl[7]  = '{51,  0, 0, 1, 3,  3, 3, 3, 0, 0, 0, 0};
        tbl[8]  = '{64,  0, 0, 0, 0,  4, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{80,  0, 1, 0, 0,  5, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{95,  0, 1, 0, 15, 5, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{96,  0, 0, 0, 0,  6, 0, 0, 1, 0, 0, 0};
        tbl[12] = '{127, 0, 0, 0, 15, 7, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{128, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 1};

        reset = 1'b0;
        en    = 1'b1;
        mon   = 1'b1;
        step(3);
        chk("reset_small", vec_s, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_default", vec_d, pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drv(1'b1, 1'b1);
        step(1);
        chk("first_default", vec_d, pk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        cur = 0;
        foreach (tbl[i]) begin
            step(tbl[i].t - cur);
            cur = tbl[i].t;
            chk($sformatf("table_t%0d", tbl[i].t), vec_s,
                pk(tbl[i].hs, tbl[i].vs, tbl[i].vl, tbl[i].h, tbl[i].v, tbl[i].hc, tbl[i].vc,
                   tbl[i].ls, tbl[i].fs, tbl[i].vb, tbl[i].fc));
        end

        // freeze on the last pixel of a frame, then resume into the next frame
        step(127);
        drv(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("frozen", vec_s, pk(0, 0, 0, 15, 7, 0, 0, 0, 0, 0, 1));
        end
        drv(1'b1, 1'b1);
        step(1);
        chk("resume", vec_s, pk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2));

        // from t=104 of frame 9, run to the start of the frame where frame_cnt reads 255
        step(1000);
        mon = 1'b0;
        step(31384);
        chk("fc_255", vec_s, pk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 255));
        mon = 1'b1;
        step(128);
        chk("fc_wrap", vec_s, pk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        step(48);
        chk("mid_frame", vec_s, pk(0, 0, 1, 0, 3, 0, 3, 1, 0, 0, 0));
        drv(1'b0, 1'b1);
        step(1);
        chk("midreset_small", vec_s, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("midreset_default", vec_d, pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drv(1'b1, 1'b1);
        step(1);
        chk("restart", vec_s, pk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        step(127);
        chk("restart_end", vec_s, pk(0, 0, 0, 15, 7, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("restart_fc1", vec_s, pk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));

        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);
            step(1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
